// File: rtl/lab_nios_system_pio_in_debounced.sv
// Debounced Avalon-MM input PIO for the Nios system.
// Each channel is synchronised through two flops and debounced with a
// software-programmable period. Rising and/or falling edges of the debounced
// level are captured, cleared by write-1-to-clear, and drive a maskable
// level interrupt.
//
// Bus semantics: a write is chipselect & ~write_n, accepted on the rising
// edge with no wait states. readdata is registered and updated on every
// clock from the current address, so the value presented after an edge
// reflects register contents from before any write on that same edge.
module lab_nios_system_pio_in_debounced #(
  parameter int               WIDTH         = 4,
  parameter int               CNT_W         = 16,
  parameter int               DB_RESET      = 50000,
  parameter logic [WIDTH-1:0] IN_RESET_VAL  = '1,
  parameter logic [WIDTH-1:0] FALL_EN_RESET = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] DB_RESET_V = CNT_W'(DB_RESET);

  localparam logic [2:0] A_DATA      = 3'd0;
  localparam logic [2:0] A_RAW       = 3'd1;
  localparam logic [2:0] A_IRQ_MASK  = 3'd2;
  localparam logic [2:0] A_EDGE_CAP  = 3'd3;
  localparam logic [2:0] A_RISE_EN   = 3'd4;
  localparam logic [2:0] A_FALL_EN   = 3'd5;
  localparam logic [2:0] A_DB_PERIOD = 3'd6;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [CNT_W-1:0] db_period;

  logic             wr_en;
  logic [CNT_W-1:0] p_last;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;

  // Bits of writedata above the register widths are deliberately ignored.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // Terminal count P-1, with a period of 0 treated as 1 (no filtering).
  assign p_last = (db_period == '0) ? '0 : (db_period - CNT_W'(1));

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  // W1C mask; only an EDGE_CAPTURE write clears anything.
  assign clr = (wr_en && (address == A_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;

  assign irq = |(cap & irq_mask);

  // Synchroniser, per-channel debounce counters and the delayed stable copy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= IN_RESET_VAL;
      sync2    <= IN_RESET_VAL;
      stable   <= IN_RESET_VAL;
      stable_d <= IN_RESET_VAL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= p_last) begin
          // >= so that shrinking the period mid-count still terminates.
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Read mux: unmapped addresses and bits above the register width read 0.
  always_comb begin
    rd_mux = 32'h0;
    case (address)
      A_DATA:      rd_mux = 32'(stable);
      A_RAW:       rd_mux = 32'(sync2);
      A_IRQ_MASK:  rd_mux = 32'(irq_mask);
      A_EDGE_CAP:  rd_mux = 32'(cap);
      A_RISE_EN:   rd_mux = 32'(rise_en);
      A_FALL_EN:   rd_mux = 32'(fall_en);
      A_DB_PERIOD: rd_mux = 32'(db_period);
      default:     rd_mux = 32'h0;
    endcase
  end

  // Control registers, edge capture (set wins over clear) and read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask  <= '0;
      cap       <= '0;
      rise_en   <= '0;
      fall_en   <= FALL_EN_RESET;
      db_period <= DB_RESET_V;
      readdata  <= 32'h0;
    end else begin
      readdata <= rd_mux;
      cap      <= (cap & ~clr) | (rise & rise_en) | (fall & fall_en);
      if (wr_en) begin
        case (address)
          A_IRQ_MASK:  irq_mask  <= writedata[WIDTH-1:0];
          A_RISE_EN:   rise_en   <= writedata[WIDTH-1:0];
          A_FALL_EN:   fall_en   <= writedata[WIDTH-1:0];
          A_DB_PERIOD: db_period <= writedata[CNT_W-1:0];
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lab_nios_system_pio_in_debounced.sv
// Bench for lab_nios_system_pio_in_debounced (WIDTH=4, CNT_W=16 defaults).
// Driver tasks push the expected response of each bus cycle into a queue;
// a monitor pops one entry per bus cycle and compares readdata / irq.
`timescale 1ns/1ps
module tb_lab_nios_system_pio_in_debounced;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  // Entry: {check_data, check_irq, irq_exp, data_exp[31:0]}
  logic [34:0] exp_q[$];
  string       name_q[$];

  int n_checks;
  int n_fail;
  logic mon_pend;

  lab_nios_system_pio_in_debounced dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A bus cycle was presented on this edge; its response is checked after it.
  always @(posedge clk) mon_pend <= chipselect;

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [34:0] e;
    string       nm;
    if (mon_pend === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL queue_underflow: bus cycle with no expected entry");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e[34]) begin
          n_checks++;
          if (readdata !== e[31:0]) begin
            n_fail++;
            $display("FAIL %s: readdata=%h expected %h", nm, readdata, e[31:0]);
          end
        end
        if (e[33]) begin
          n_checks++;
          if (irq !== e[32]) begin
            n_fail++;
            $display("FAIL %s_irq: irq=%b expected %b", nm, irq, e[32]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] d,
                    input logic ci, input logic ie, input string nm);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back({1'b1, ci, ie, d});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic ci, input logic ie, input string nm);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    exp_q.push_back({1'b0, ci, ie, 32'h0});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr_plain(input logic [2:0] a, input logic [31:0] d);
    wr(a, d, 1'b0, 1'b0, "wr");
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    mon_pend   = 1'b0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;

    // Reset: three edges low, then release
    tick(3);
    reset_n = 1'b1;
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_readdata: readdata=%h expected %h", readdata, 32'h0);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: irq=%b expected %b", irq, 1'b0);
    end
    rd(3'd5, 32'hF,     1, 0, "reset_fall_en");
    rd(3'd6, 32'd50000, 1, 0, "reset_db_period");
    rd(3'd3, 32'h0,     1, 0, "reset_cap");
    rd(3'd2, 32'h0,     1, 0, "reset_irq_mask");
    rd(3'd4, 32'h0,     1, 0, "reset_rise_en");
    rd(3'd0, 32'hF,     1, 0, "reset_data");
    rd(3'd1, 32'hF,     1, 0, "reset_raw");
    rd(3'd7, 32'h0,     1, 0, "unmapped_rd");

    // Debounce with P = 8: a 5-cycle glitch must not pass
    wr_plain(3'd6, 32'd8);
    rd(3'd6, 32'd8, 1, 0, "db_period_rd");
    wr_plain(3'd2, 32'h1);
    in_port = 4'hE;
    for (int j = 0; j < 5; j++) rd(3'd0, 32'hF, 1, 0, "glitch_data");
    in_port = 4'hF;
    for (int j = 0; j < 8; j++) rd(3'd0, 32'hF, 1, 0, "glitch_after");
    rd(3'd3, 32'h0, 1, 0, "glitch_no_cap");

    // Held low: stable at edge k+9 (DATA seen at k+10), cap/irq at k+10
    in_port = 4'hE;
    for (int j = 0; j <= 10; j++)
      rd(3'd0, (j >= 10) ? 32'hE : 32'hF, 1, (j >= 10), "fall_latency");
    rd(3'd3, 32'h1, 1, 1, "fall_cap");
    wr(3'd3, 32'h1, 1, 0, "w1c_bit0");
    in_port = 4'hF;
    tick(12);
    rd(3'd3, 32'h0, 1, 0, "rise_not_enabled");
    rd(3'd0, 32'hF, 1, 0, "data_high_again");

    // Period 0 behaves as 1: stable follows sync2 one cycle later
    wr_plain(3'd6, 32'd0);
    rd(3'd6, 32'd0, 1, 0, "db_period_zero");
    in_port = 4'h7;
    rd(3'd1, 32'hF, 1, 0, "bypass_raw0");
    rd(3'd1, 32'hF, 1, 0, "bypass_raw1");
    rd(3'd1, 32'h7, 1, 0, "bypass_raw2");
    rd(3'd0, 32'h7, 1, 0, "bypass_data3");
    in_port = 4'hF;
    rd(3'd0, 32'h7, 1, 0, "bypass_back0");
    rd(3'd0, 32'h7, 1, 0, "bypass_back1");
    rd(3'd0, 32'h7, 1, 0, "bypass_back2");
    rd(3'd0, 32'hF, 1, 0, "bypass_back3");
    rd(3'd3, 32'h8, 1, 0, "bypass_cap_masked");
    wr_plain(3'd3, 32'hF);

    // Edge modes: rise only on bit 1
    wr_plain(3'd4, 32'h2);
    wr_plain(3'd5, 32'h0);
    in_port = 4'hD;
    tick(4);
    rd(3'd3, 32'h0, 1, 0, "rise_only_fall");
    in_port = 4'hF;
    tick(4);
    rd(3'd3, 32'h2, 1, 0, "rise_only_rise");
    wr_plain(3'd3, 32'hF);
    rd(3'd3, 32'h0, 1, 0, "rise_only_cleared");

    // Both enables: both transitions capture
    wr_plain(3'd4, 32'hF);
    wr_plain(3'd5, 32'hF);
    in_port = 4'hD;
    tick(4);
    rd(3'd3, 32'h2, 1, 0, "both_fall");
    wr_plain(3'd3, 32'h2);
    rd(3'd3, 32'h0, 1, 0, "both_cleared");
    in_port = 4'hF;
    tick(4);
    rd(3'd3, 32'h2, 1, 0, "both_rise");
    wr_plain(3'd3, 32'hF);

    // W1C and IRQ
    wr_plain(3'd2, 32'h3);
    in_port = 4'hC;
    tick(4);
    rd(3'd3, 32'h3, 1, 1, "w1c_cap11");
    wr(3'd3, 32'h1, 1, 1, "w1c_partial");
    rd(3'd3, 32'h2, 1, 1, "w1c_cap10");
    wr(3'd3, 32'h2, 1, 0, "w1c_irq_fall");
    rd(3'd3, 32'h0, 1, 0, "w1c_cap00");
    in_port = 4'hF;
    tick(4);
    rd(3'd3, 32'h3, 1, 1, "w1c_rise_cap");
    wr(3'd3, 32'hF, 1, 0, "w1c_all");

    // Mask clear drops irq on its own edge
    in_port = 4'hC;
    tick(4);
    wr(3'd2, 32'h0, 1, 0, "mask_clear");
    rd(3'd3, 32'h3, 1, 0, "mask_clear_cap_kept");
    wr_plain(3'd3, 32'hF);
    in_port = 4'hF;
    tick(4);
    wr_plain(3'd3, 32'hF);
    rd(3'd3, 32'h0, 1, 0, "pre_collision_cap");

    // Set/clear collision on bit 2: set wins
    wr_plain(3'd2, 32'h4);
    in_port = 4'hB;
    tick(3);
    wr(3'd3, 32'h4, 1, 1, "collision");
    rd(3'd3, 32'h4, 1, 1, "collision_cap");
    wr(3'd3, 32'h4, 1, 0, "w1c_bit2");
    rd(3'd3, 32'h0, 1, 0, "w1c_bit2_cap");
    in_port = 4'hF;
    tick(4);
    wr_plain(3'd3, 32'hF);

    // Width rule and ignored writes
    wr_plain(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, 32'h0000_000F, 1, 0, "mask_width");
    wr_plain(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0000_FFFF, 1, 0, "period_width");
    wr_plain(3'd7, 32'h1234_5678);
    rd(3'd7, 32'h0, 1, 0, "unmapped_after_wr");
    wr_plain(3'd0, 32'h0);
    rd(3'd0, 32'hF, 1, 0, "data_ro");
    wr_plain(3'd1, 32'h0);
    rd(3'd1, 32'hF, 1, 0, "raw_ro");

    tick(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
